decode_stage: RTL and testbench
===============================

# decode_stage

Registered instruction-decode stage for the pipelined MIPS core. It sits between fetch and execute, translating each 32-bit instruction into the 6-bit ALU function code, operand selects, extended immediate and register/memory controls that the execute-stage ALU consumes. It supports pipeline stall and flush and counts illegal instructions. Latency is one cycle.

## Interface
- No parameters. All encodings are fixed constants (see Structure).
- clk  in  1  sole clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- Instr_in  in  32  instruction word from fetch
- Valid_in  in  1  Instr_in holds a real instruction
- Stall_in  in  1  hold all outputs this cycle
- Flush_in  in  1  replace the next output with a bubble
- Func_out  out  6  ALU function code
- ASel_out  out  2  ALU A source: 00 rs, 01 rt, 10 Imm_out
- BSel_out  out  2  ALU B source: 00 rt, 01 Imm_out, 10 shamt (Instr[10:6]), 11 constant 16
- Imm_out  out  32  extended immediate
- Rs_out, Rt_out  out  5 each  source register numbers
- Rd_out  out  5  destination register: rd, rt or 31
- RegWrite_out, MemRead_out, MemWrite_out, Link_out  out  1 each  control bits
- Valid_out  out  1  outputs describe a real instruction
- Illegal_out  out  1  one-cycle pulse: the decoded word was undefined
- Illegal_count_out  out  8  saturating count of illegal instructions

## Operation
- ALU codes: ADD 100000, SUB 100010, AND 100100, OR 100101, XOR 100110, NOR 100111, SLT 101000, SLTU 101001, BLTZ 111000, BGEZ 111001, J/JAL 111010, JR/JALR 111011, BEQ 111100, BNE 111101, BLEZ 111110, BGTZ 111111, SLL 000000, SRL 000011.
- R-type (op 000000), keyed on funct:
  - add/addu → ADD; sub/subu → SUB; and/or/xor/nor → the matching logic code; slt → SLT; sltu → SLTU.
  - For all of these: A=rs, B=rt, Rd=rd, RegWrite=1.
  - sll (000000) → SLL; srl (000010) → SRL. For both: A=rt, B=shamt, Rd=rd, RegWrite=1.
  - jr → JR/JALR, A=rs, RegWrite=0.
  - jalr → JR/JALR, A=rs, Rd=rd, RegWrite=1, Link=1.
- REGIMM (op 000001): rt=00000 → BLTZ; rt=00001 → BGEZ. A=rs, RegWrite=0.
- J (000010) → J/JAL. JAL (000011) → J/JAL, Rd=31, RegWrite=1, Link=1. For both: Imm_out={4'b0, Instr[25:0], 2'b00}; fetch merges PC[31:28].
- BEQ/BNE: A=rs, B=rt. BLEZ/BGTZ: A=rs. Imm_out = sign-extended offset (unshifted).
- ADDI/ADDIU → ADD. SLTI → SLT. SLTIU → SLTU. For all four: A=rs, B=Imm_out (sign-extended), Rd=rt, RegWrite=1.
- ANDI/ORI/XORI → AND/OR/XOR: A=rs, B=Imm_out (zero-extended), Rd=rt, RegWrite=1.
- LUI → SLL: A=Imm_out (zero-extended), B=const 16, Rd=rt, RegWrite=1.
- LW (100011) → ADD: A=rs, B=sign-extended Imm_out, Rd=rt, RegWrite=1, MemRead=1.
- SW (101011) → ADD: same operands as LW, MemWrite=1, RegWrite=0.
- Any RegWrite with Rd=0 is forced to RegWrite=0.
- Any other opcode/funct/rt combination is illegal:
  - Output is a bubble.
  - Illegal_out pulses for that cycle.
  - Illegal_count_out increments and saturates at 255.
- Bubble:
  - Func=000000, ASel=BSel=00, Imm=0, Rs=Rt=Rd=0.
  - All control bits 0, Valid_out=0.
  - Valid_in=0 also yields a bubble (not illegal).

## Timing
- Outputs are registered and appear one cycle after Instr_in is sampled.
- Reset: every output takes its bubble value; Illegal_out=0 and Illegal_count_out=0. Reset takes effect immediately, mid-instruction included.
- Per-edge priority: reset > Flush_in > Stall_in > normal decode.
- Flush_in=1: bubble next cycle regardless of Stall_in. The counter is not incremented, even if Instr_in is illegal.
- Stall_in=1 (no flush): all outputs hold. Illegal_out drops to 0 and the counter does not increment, so a held illegal word is counted once.
- Consecutive illegal words each count. At 255 the counter holds.

## Structure
- Shared package `mips_defs`: opcode, funct and REGIMM rt constants; ALU Func codes (shared with the execute ALU); ASel/BSel encodings.
- One natural combinational sub-module, `instr_decode`: Instr_in → next control bundle plus an illegal flag.
- `decode_stage` itself holds the pipeline register, flush/stall priority and the saturating counter.

## Test plan
- Reset asserted mid-stream with valid outputs → all outputs bubble, count=0, within the same cycle.
- `add $3,$1,$2` (0x00221820) → Func=100000, ASel=00, BSel=00, Rs=1, Rt=2, Rd=3, RegWrite=1, Valid=1 one cycle later.
- `lui $5,0xABCD` (0x3C05ABCD) → Func=000000, ASel=10, BSel=11, Imm=0x0000ABCD, Rd=5; `lw $4,-4($29)` (0x8FA4FFFC) → Func=100000, Imm=0xFFFFFFFC, MemRead=1.
- `jal 0x0100000` (0x0C100000) → Func=111010, Imm=0x00400000, Rd=31, Link=1; `bgez $7,8` (0x04E10008) → Func=111001, Imm=0x00000008, RegWrite=0.
- Stall held 3 cycles on `sub` → outputs frozen; Flush and Stall asserted together → bubble, Valid=0.
- Illegal op 0x3F repeated 300 valid cycles → Illegal_out pulses each cycle, count saturates at 255; same word under Stall counts once.

Source files
------------

// File: rtl/decode_stage_pkg.sv
// Shared MIPS decode constants: opcode/funct/REGIMM fields, ALU function codes
// and operand-select encodings used by decode and the execute-stage ALU.
package mips_defs;

    localparam logic [5:0] OP_RTYPE  = 6'b000000;
    localparam logic [5:0] OP_REGIMM = 6'b000001;
    localparam logic [5:0] OP_J      = 6'b000010;
    localparam logic [5:0] OP_JAL    = 6'b000011;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_BNE    = 6'b000101;
    localparam logic [5:0] OP_BLEZ   = 6'b000110;
    localparam logic [5:0] OP_BGTZ   = 6'b000111;
    localparam logic [5:0] OP_ADDI   = 6'b001000;
    localparam logic [5:0] OP_ADDIU  = 6'b001001;
    localparam logic [5:0] OP_SLTI   = 6'b001010;
    localparam logic [5:0] OP_SLTIU  = 6'b001011;
    localparam logic [5:0] OP_ANDI   = 6'b001100;
    localparam logic [5:0] OP_ORI    = 6'b001101;
    localparam logic [5:0] OP_XORI   = 6'b001110;
    localparam logic [5:0] OP_LUI    = 6'b001111;
    localparam logic [5:0] OP_LW     = 6'b100011;
    localparam logic [5:0] OP_SW     = 6'b101011;

    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;
    localparam logic [5:0] FN_JR   = 6'b001000;
    localparam logic [5:0] FN_JALR = 6'b001001;
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_XOR  = 6'b100110;
    localparam logic [5:0] FN_NOR  = 6'b100111;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_SLTU = 6'b101011;

    localparam logic [4:0] RT_BLTZ = 5'b00000;
    localparam logic [4:0] RT_BGEZ = 5'b00001;

    typedef enum logic [5:0] {
        ALU_SLL  = 6'b000000,
        ALU_SRL  = 6'b000011,
        ALU_ADD  = 6'b100000,
        ALU_SUB  = 6'b100010,
        ALU_AND  = 6'b100100,
        ALU_OR   = 6'b100101,
        ALU_XOR  = 6'b100110,
        ALU_NOR  = 6'b100111,
        ALU_SLT  = 6'b101000,
        ALU_SLTU = 6'b101001,
        ALU_BLTZ = 6'b111000,
        ALU_BGEZ = 6'b111001,
        ALU_J    = 6'b111010,
        ALU_JR   = 6'b111011,
        ALU_BEQ  = 6'b111100,
        ALU_BNE  = 6'b111101,
        ALU_BLEZ = 6'b111110,
        ALU_BGTZ = 6'b111111
    } alu_func_e;

    typedef enum logic [1:0] {
        ASEL_RS  = 2'b00,
        ASEL_RT  = 2'b01,
        ASEL_IMM = 2'b10
    } asel_e;

    typedef enum logic [1:0] {
        BSEL_RT    = 2'b00,
        BSEL_IMM   = 2'b01,
        BSEL_SHAMT = 2'b10,
        BSEL_C16   = 2'b11
    } bsel_e;

    typedef struct packed {
        alu_func_e   func;
        asel_e       asel;
        bsel_e       bsel;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        link;
        logic        valid;
    } ctl_t;

    localparam ctl_t CTL_BUBBLE = '{
        func: ALU_SLL, asel: ASEL_RS, bsel: BSEL_RT, imm: '0,
        rs: '0, rt: '0, rd: '0,
        reg_write: 1'b0, mem_read: 1'b0, mem_write: 1'b0, link: 1'b0, valid: 1'b0
    };

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-to-decode inputs and decode-to-execute control bundle of the decode stage.
interface decode_stage_if;

    logic [31:0] Instr_in;
    logic        Valid_in;
    logic        Stall_in;
    logic        Flush_in;

    logic [5:0]  Func_out;
    logic [1:0]  ASel_out;
    logic [1:0]  BSel_out;
    logic [31:0] Imm_out;
    logic [4:0]  Rs_out;
    logic [4:0]  Rt_out;
    logic [4:0]  Rd_out;
    logic        RegWrite_out;
    logic        MemRead_out;
    logic        MemWrite_out;
    logic        Link_out;
    logic        Valid_out;
    logic        Illegal_out;
    logic [7:0]  Illegal_count_out;

    modport master (
        output Instr_in, Valid_in, Stall_in, Flush_in,
        input  Func_out, ASel_out, BSel_out, Imm_out, Rs_out, Rt_out, Rd_out,
               RegWrite_out, MemRead_out, MemWrite_out, Link_out, Valid_out,
               Illegal_out, Illegal_count_out
    );

    modport slave (
        input  Instr_in, Valid_in, Stall_in, Flush_in,
        output Func_out, ASel_out, BSel_out, Imm_out, Rs_out, Rt_out, Rd_out,
               RegWrite_out, MemRead_out, MemWrite_out, Link_out, Valid_out,
               Illegal_out, Illegal_count_out
    );

endinterface

// File: rtl/decode_stage_instr_decode.sv
// Combinational MIPS instruction decoder: 32-bit word to execute control bundle,
// plus a flag for undefined opcode/funct/REGIMM-rt combinations.
module instr_decode
    import mips_defs::*;
(
    input  logic [31:0] instr_i,
    output ctl_t        ctl_o,
    output logic        illegal_o
);

    logic [5:0]  op;
    logic [5:0]  fn;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] imm_sx;
    logic [31:0] imm_zx;

    assign op     = instr_i[31:26];
    assign rs     = instr_i[25:21];
    assign rt     = instr_i[20:16];
    assign rd     = instr_i[15:11];
    assign fn     = instr_i[5:0];
    assign imm_sx = sext16(instr_i[15:0]);
    assign imm_zx = {16'h0000, instr_i[15:0]};

    always_comb begin
        ctl_o       = CTL_BUBBLE;
        ctl_o.valid = 1'b1;
        ctl_o.rs    = rs;
        ctl_o.rt    = rt;
        illegal_o   = 1'b0;

        case (op)
            OP_RTYPE: begin
                ctl_o.rd        = rd;
                ctl_o.reg_write = 1'b1;
                case (fn)
                    FN_ADD, FN_ADDU: ctl_o.func = ALU_ADD;
                    FN_SUB, FN_SUBU: ctl_o.func = ALU_SUB;
                    FN_AND:          ctl_o.func = ALU_AND;
                    FN_OR:           ctl_o.func = ALU_OR;
                    FN_XOR:          ctl_o.func = ALU_XOR;
                    FN_NOR:          ctl_o.func = ALU_NOR;
                    FN_SLT:          ctl_o.func = ALU_SLT;
                    FN_SLTU:         ctl_o.func = ALU_SLTU;
                    FN_SLL, FN_SRL: begin
                        ctl_o.func = (fn == FN_SLL) ? ALU_SLL : ALU_SRL;
                        ctl_o.asel = ASEL_RT;
                        ctl_o.bsel = BSEL_SHAMT;
                    end
                    FN_JR: begin
                        ctl_o.func      = ALU_JR;
                        ctl_o.rd        = '0;
                        ctl_o.reg_write = 1'b0;
                    end
                    FN_JALR: begin
                        ctl_o.func = ALU_JR;
                        ctl_o.link = 1'b1;
                    end
                    default: illegal_o = 1'b1;
                endcase
            end
            OP_REGIMM: begin
                ctl_o.imm = imm_sx;
                case (rt)
                    RT_BLTZ: ctl_o.func = ALU_BLTZ;
                    RT_BGEZ: ctl_o.func = ALU_BGEZ;
                    default: illegal_o = 1'b1;
                endcase
            end
            OP_J, OP_JAL: begin
                ctl_o.func = ALU_J;
                ctl_o.imm  = {4'b0000, instr_i[25:0], 2'b00};
                if (op == OP_JAL) begin
                    ctl_o.rd        = 5'd31;
                    ctl_o.reg_write = 1'b1;
                    ctl_o.link      = 1'b1;
                end
            end
            OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: begin
                ctl_o.imm = imm_sx;
                case (op)
                    OP_BEQ:  ctl_o.func = ALU_BEQ;
                    OP_BNE:  ctl_o.func = ALU_BNE;
                    OP_BLEZ: ctl_o.func = ALU_BLEZ;
                    default: ctl_o.func = ALU_BGTZ;
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_LW: begin
                ctl_o.bsel      = BSEL_IMM;
                ctl_o.imm       = imm_sx;
                ctl_o.rd        = rt;
                ctl_o.reg_write = 1'b1;
                ctl_o.mem_read  = (op == OP_LW);
                case (op)
                    OP_SLTI:  ctl_o.func = ALU_SLT;
                    OP_SLTIU: ctl_o.func = ALU_SLTU;
                    default:  ctl_o.func = ALU_ADD;
                endcase
            end
            OP_ANDI, OP_ORI, OP_XORI: begin
                ctl_o.bsel      = BSEL_IMM;
                ctl_o.imm       = imm_zx;
                ctl_o.rd        = rt;
                ctl_o.reg_write = 1'b1;
                case (op)
                    OP_ANDI: ctl_o.func = ALU_AND;
                    OP_ORI:  ctl_o.func = ALU_OR;
                    default: ctl_o.func = ALU_XOR;
                endcase
            end
            OP_LUI: begin
                ctl_o.func      = ALU_SLL;
                ctl_o.asel      = ASEL_IMM;
                ctl_o.bsel      = BSEL_C16;
                ctl_o.imm       = imm_zx;
                ctl_o.rd        = rt;
                ctl_o.reg_write = 1'b1;
            end
            OP_SW: begin
                ctl_o.func      = ALU_ADD;
                ctl_o.bsel      = BSEL_IMM;
                ctl_o.imm       = imm_sx;
                ctl_o.mem_write = 1'b1;
            end
            default: illegal_o = 1'b1;
        endcase

        // Writes to $0 are architecturally discarded, so never request them.
        if (ctl_o.rd == 5'd0) begin
            ctl_o.reg_write = 1'b0;
        end
        if (illegal_o) begin
            ctl_o = CTL_BUBBLE;
        end
    end

endmodule

// File: rtl/decode_stage.sv
// Registered MIPS decode stage: pipeline register with flush/stall priority
// and a saturating count of undefined instructions.
module decode_stage
    import mips_defs::*;
(
    input  logic          clk,
    input  logic          reset,
    decode_stage_if.slave bus
);

    ctl_t       dec_ctl;
    logic       dec_illegal;
    ctl_t       ctl_q, ctl_d;
    logic       illegal_q, illegal_d;
    logic [7:0] count_q, count_d;

    instr_decode u_instr_decode (
        .instr_i   (bus.Instr_in),
        .ctl_o     (dec_ctl),
        .illegal_o (dec_illegal)
    );

    always_comb begin
        ctl_d     = ctl_q;
        illegal_d = 1'b0;
        count_d   = count_q;
        if (bus.Flush_in) begin
            ctl_d = CTL_BUBBLE;
        end else if (bus.Stall_in) begin
            ctl_d = ctl_q;
        end else if (!bus.Valid_in) begin
            ctl_d = CTL_BUBBLE;
        end else if (dec_illegal) begin
            ctl_d     = CTL_BUBBLE;
            illegal_d = 1'b1;
            count_d   = (count_q == 8'hFF) ? count_q : count_q + 8'd1;
        end else begin
            ctl_d = dec_ctl;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctl_q     <= CTL_BUBBLE;
            illegal_q <= 1'b0;
            count_q   <= '0;
        end else begin
            ctl_q     <= ctl_d;
            illegal_q <= illegal_d;
            count_q   <= count_d;
        end
    end

    assign bus.Func_out          = ctl_q.func;
    assign bus.ASel_out          = ctl_q.asel;
    assign bus.BSel_out          = ctl_q.bsel;
    assign bus.Imm_out           = ctl_q.imm;
    assign bus.Rs_out            = ctl_q.rs;
    assign bus.Rt_out            = ctl_q.rt;
    assign bus.Rd_out            = ctl_q.rd;
    assign bus.RegWrite_out      = ctl_q.reg_write;
    assign bus.MemRead_out       = ctl_q.mem_read;
    assign bus.MemWrite_out      = ctl_q.mem_write;
    assign bus.Link_out          = ctl_q.link;
    assign bus.Valid_out         = ctl_q.valid;
    assign bus.Illegal_out       = illegal_q;
    assign bus.Illegal_count_out = count_q;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: driver pushes reference-model expectations,
// monitor pops one per cycle and compares against the registered outputs.
module tb_decode_stage;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    decode_stage_if bus ();

    decode_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [5:0]  func;
        logic [1:0]  asel;
        logic [1:0]  bsel;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        lk;
        logic        vld;
        logic        ill;
        logic [7:0]  cnt;
    } obs_t;

    int    checks   = 0;
    int    failures = 0;
    obs_t  expq[$];
    string tagq[$];
    obs_t  m;
    string cur_tag;
    int    rfunc[int];

    function automatic obs_t bubble(input logic [7:0] c);
        obs_t b;
        b     = '0;
        b.cnt = c;
        return b;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.func = bus.Func_out;      o.asel = bus.ASel_out;      o.bsel = bus.BSel_out;
        o.imm  = bus.Imm_out;       o.rs   = bus.Rs_out;        o.rt   = bus.Rt_out;
        o.rd   = bus.Rd_out;        o.rw   = bus.RegWrite_out;  o.mr   = bus.MemRead_out;
        o.mw   = bus.MemWrite_out;  o.lk   = bus.Link_out;      o.vld  = bus.Valid_out;
        o.ill  = bus.Illegal_out;   o.cnt  = bus.Illegal_count_out;
        return o;
    endfunction

    task automatic check(input string name, input obs_t act, input obs_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference decoder built from the instruction-set rules.
    function automatic void ref_decode(input logic [31:0] w, output obs_t o, output logic ill);
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [4:0]  rt;
        logic [31:0] sx;
        logic [31:0] zx;
        op  = w[31:26];
        fn  = w[5:0];
        rt  = w[20:16];
        sx  = {{16{w[15]}}, w[15:0]};
        zx  = {16'h0000, w[15:0]};
        o     = '0;
        ill   = 1'b0;
        o.vld = 1'b1;
        o.rs  = w[25:21];
        o.rt  = rt;
        case (op)
            6'd0: begin
                if (rfunc.exists(int'(fn))) begin
                    o.func = 6'(rfunc[int'(fn)]);
                    o.rd   = w[15:11];
                    o.rw   = 1'b1;
                    if (fn == 6'd0 || fn == 6'd2) begin o.asel = 2'd1; o.bsel = 2'd2; end
                    if (fn == 6'd8) begin o.rd = 5'd0; o.rw = 1'b0; end
                    if (fn == 6'd9) o.lk = 1'b1;
                end else ill = 1'b1;
            end
            6'd1: begin
                if (rt < 5'd2) begin o.func = 6'd56 + 6'(rt); o.imm = sx; end
                else ill = 1'b1;
            end
            6'd2, 6'd3: begin
                o.func = 6'd58;
                o.imm  = {4'b0000, w[25:0], 2'b00};
                if (op == 6'd3) begin o.rd = 5'd31; o.rw = 1'b1; o.lk = 1'b1; end
            end
            6'd4, 6'd5, 6'd6, 6'd7: begin o.func = 6'd60 + (op - 6'd4); o.imm = sx; end
            6'd8, 6'd9, 6'd10, 6'd11, 6'd35: begin
                o.func = (op == 6'd10) ? 6'd40 : (op == 6'd11) ? 6'd41 : 6'd32;
                o.bsel = 2'd1; o.imm = sx; o.rd = rt; o.rw = 1'b1;
                o.mr   = (op == 6'd35);
            end
            6'd12, 6'd13, 6'd14: begin
                o.func = 6'd36 + (op - 6'd12);
                o.bsel = 2'd1; o.imm = zx; o.rd = rt; o.rw = 1'b1;
            end
            6'd15: begin
                o.func = 6'd0; o.asel = 2'd2; o.bsel = 2'd3; o.imm = zx; o.rd = rt; o.rw = 1'b1;
            end
            6'd43: begin o.func = 6'd32; o.bsel = 2'd1; o.imm = sx; o.mw = 1'b1; end
            default: ill = 1'b1;
        endcase
        if (o.rd == 5'd0) o.rw = 1'b0;
    endfunction

    // Drive one cycle of inputs, advance the model, hand the expectation to the monitor.
    task automatic step(input string tag, input logic [31:0] w, input logic v,
                        input logic s, input logic f);
        obs_t  d;
        logic  ill;
        bus.Instr_in = w;
        bus.Valid_in = v;
        bus.Stall_in = s;
        bus.Flush_in = f;
        if (f) begin
            m = bubble(m.cnt);
        end else if (s) begin
            m.ill = 1'b0;
        end else if (!v) begin
            m = bubble(m.cnt);
        end else begin
            ref_decode(w, d, ill);
            if (ill) begin
                m     = bubble((m.cnt == 8'd255) ? 8'd255 : m.cnt + 8'd1);
                m.ill = 1'b1;
            end else begin
                d.cnt = m.cnt;
                m     = d;
            end
        end
        @(posedge clk);
        #1;
        expq.push_back(m);
        tagq.push_back(tag);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        int          fl[14];
        int          ol[16];
        fl = '{0, 2, 8, 9, 32, 33, 34, 35, 36, 37, 38, 39, 42, 43};
        ol = '{2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 35, 43};
        w = $urandom;
        case ($urandom_range(0, 4))
            0: begin w[31:26] = 6'd0; w[5:0] = 6'(fl[$urandom_range(0, 13)]); end
            1: begin w[31:26] = 6'd1; w[20:16] = 5'($urandom_range(0, 2)); end
            2, 3: w[31:26] = 6'(ol[$urandom_range(0, 15)]);
            default: ;
        endcase
        if ($urandom_range(0, 7) == 0) w[15:11] = 5'd0;
        if ($urandom_range(0, 7) == 0) w[20:16] = 5'd0;
        return w;
    endfunction

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (expq.size() != 0) begin
                cur_tag = tagq.pop_front();
                check(cur_tag, sample(), expq.pop_front());
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "timeout");
    end

    initial begin : driver
        rfunc[32] = 32; rfunc[33] = 32; rfunc[34] = 34; rfunc[35] = 34;
        rfunc[36] = 36; rfunc[37] = 37; rfunc[38] = 38; rfunc[39] = 39;
        rfunc[42] = 40; rfunc[43] = 41; rfunc[0]  = 0;  rfunc[2]  = 3;
        rfunc[8]  = 59; rfunc[9]  = 59;

        reset = 1'b1;
        bus.Instr_in = '0; bus.Valid_in = 1'b0; bus.Stall_in = 1'b0; bus.Flush_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", sample(), bubble(8'd0));
        reset = 1'b0;
        m = bubble(8'd0);

        step("add", 32'h00221820, 1'b1, 1'b0, 1'b0);
        step("lui", 32'h3C05ABCD, 1'b1, 1'b0, 1'b0);
        step("lw", 32'h8FA4FFFC, 1'b1, 1'b0, 1'b0);
        step("jal", 32'h0C100000, 1'b1, 1'b0, 1'b0);
        step("bgez", 32'h04E10008, 1'b1, 1'b0, 1'b0);
        step("sub", 32'h00221822, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step("stall_hold", rand_instr(), 1'b1, 1'b1, 1'b0);
        step("after_stall", 32'h00221820, 1'b1, 1'b0, 1'b0);
        step("flush_stall", 32'h00221820, 1'b1, 1'b1, 1'b1);
        step("flush_illegal", 32'hFC000000, 1'b1, 1'b0, 1'b1);
        step("invalid_illegal", 32'hFC000000, 1'b0, 1'b0, 1'b0);
        step("rd0_addi", 32'h20200005, 1'b1, 1'b0, 1'b0);
        step("jalr", 32'h0020F809, 1'b1, 1'b0, 1'b0);
        step("srl", 32'h00021882, 1'b1, 1'b0, 1'b0);

        for (int i = 0; i < 400; i++) begin
            step("random", rand_instr(), ($urandom_range(0, 9) != 0),
                 ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0));
        end

        step("pre_reset_add", 32'h00221820, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("midstream_reset", sample(), bubble(8'd0));
        @(posedge clk);
        #1;
        reset = 1'b0;
        m = bubble(8'd0);

        step("illegal_once", 32'hFC001234, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step("illegal_stalled", 32'hFC001234, 1'b1, 1'b1, 1'b0);
        step("bubble_after", 32'h00000000, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 300; i++) step("illegal_sat", 32'hFC000000 | $urandom_range(0, 65535), 1'b1, 1'b0, 1'b0);
        step("sat_stall", 32'hFC000000, 1'b1, 1'b1, 1'b0);
        step("sat_legal", 32'h00221820, 1'b1, 1'b0, 1'b0);

        repeat (2) @(posedge clk);
        checks++;
        if (expq.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d required=0", expq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
